mem_port_sched: RTL and testbench

Sequential scheduler that owns the single data-memory port behind the load/store unit. It accepts one load request (LSQ issue side) and one committed-store request (ROB retirement side) and arbitrates between them, with stores favoured and loads protected by a starvation guard. It runs a req/ack handshake to data memory and returns completed loads (byte-lane selected, sign-extended) and store-done pulses. It sits between the LSQ/LSU path and the data memory.

---
 rtl/mem_port_sched_if.sv | 37 +++
 rtl/mem_port_sched.sv | 87 ++++++++
 tb/tb_mem_port_sched.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/mem_port_sched_if.sv
// mem_port_sched_if: load, store, memory and completion signals of the data-memory port scheduler
interface mem_port_sched_if;
  logic        ld_valid;
  logic [3:0]  ld_op;
  logic [31:0] ld_addr;
  logic [31:0] ld_pc;
  logic        ld_ready;
  logic        st_valid;
  logic [3:0]  st_op;
  logic [31:0] st_addr;
  logic [31:0] st_data;
  logic [31:0] st_pc;
  logic        st_ready;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        ld_done;
  logic [31:0] ld_done_pc;
  logic [31:0] ld_done_data;
  logic        st_done;
  logic [31:0] st_done_pc;
  logic        done_err;
  modport slave (
    input  ld_valid, ld_op, ld_addr, ld_pc, st_valid, st_op, st_addr, st_data, st_pc, mem_ack, mem_rdata,
    output ld_ready, st_ready, mem_req, mem_we, mem_addr, mem_wstrb, mem_wdata,
           ld_done, ld_done_pc, ld_done_data, st_done, st_done_pc, done_err
  );
  modport master (
    output ld_valid, ld_op, ld_addr, ld_pc, st_valid, st_op, st_addr, st_data, st_pc, mem_ack, mem_rdata,
    input  ld_ready, st_ready, mem_req, mem_we, mem_addr, mem_wstrb, mem_wdata,
           ld_done, ld_done_pc, ld_done_data, st_done, st_done_pc, done_err
  );
endinterface

// File: rtl/mem_port_sched.sv
// mem_port_sched: store-favoured load/store arbiter with starvation guard driving one data-memory port
module mem_port_sched #(
  parameter int STARVE_LIMIT = 4
) (
  input logic clk,
  input logic rstn,
  mem_port_sched_if.slave bus
);
  typedef enum logic {IDLE, MEM_WAIT} state_t;
  state_t state, state_n;
  logic [3:0] streak;
  logic ld_win, ld_acc, st_acc, grant, ld_ok, st_ok, acc_ok, done, sb;
  logic is_ld, lb_q;
  logic [1:0] lane_q;
  logic [31:0] pc_q;
  logic [7:0] rd_byte;
  assign ld_win = bus.ld_valid && (!bus.st_valid || streak == 4'(STARVE_LIMIT));
  assign bus.ld_ready = rstn && state == IDLE && ld_win;
  assign bus.st_ready = rstn && state == IDLE && bus.st_valid && !ld_win;
  assign ld_acc = bus.ld_ready;
  assign st_acc = bus.st_ready;
  assign grant = ld_acc || st_acc;
  assign ld_ok = bus.ld_op == 4'd7 || (bus.ld_op == 4'd8 && bus.ld_addr[1:0] == 2'b00);
  assign st_ok = bus.st_op == 4'd9 || (bus.st_op == 4'd10 && bus.st_addr[1:0] == 2'b00);
  assign acc_ok = ld_acc ? ld_ok : st_ok;
  assign done = state == MEM_WAIT && bus.mem_ack;
  assign sb = bus.st_op == 4'd9;
  assign rd_byte = 8'(bus.mem_rdata >> {lane_q, 3'b000});
  assign bus.mem_req = state == MEM_WAIT;
  always_comb begin
    state_n = state;
    if (state == IDLE && grant && acc_ok) state_n = MEM_WAIT;
    else if (done) state_n = IDLE;
  end
  always_ff @(posedge clk) state <= !rstn ? IDLE : state_n;
  always_ff @(posedge clk)
    if (!rstn) begin
      streak <= '0;
      is_ld <= 1'b0;
      lb_q <= 1'b0;
      lane_q <= '0;
      pc_q <= '0;
      bus.mem_we <= 1'b0;
      bus.mem_addr <= '0;
      bus.mem_wstrb <= '0;
      bus.mem_wdata <= '0;
      bus.ld_done <= 1'b0;
      bus.st_done <= 1'b0;
      bus.done_err <= 1'b0;
      bus.ld_done_pc <= '0;
      bus.ld_done_data <= '0;
      bus.st_done_pc <= '0;
    end else begin
      bus.ld_done <= 1'b0;
      bus.st_done <= 1'b0;
      bus.done_err <= 1'b0;
      // a store grant only extends the streak when a load was left waiting
      if (grant) streak <= (ld_acc || !bus.ld_valid) ? 4'd0 : (streak == 4'(STARVE_LIMIT) ? streak : streak + 4'd1);
      if (grant && !acc_ok) begin
        bus.ld_done <= ld_acc;
        bus.st_done <= st_acc;
        bus.done_err <= 1'b1;
        if (ld_acc) begin
          bus.ld_done_pc <= bus.ld_pc;
          bus.ld_done_data <= '0;
        end else bus.st_done_pc <= bus.st_pc;
      end
      if (grant && acc_ok) begin
        is_ld <= ld_acc;
        lb_q <= ld_acc && bus.ld_op == 4'd7;
        lane_q <= ld_acc ? bus.ld_addr[1:0] : bus.st_addr[1:0];
        pc_q <= ld_acc ? bus.ld_pc : bus.st_pc;
        bus.mem_we <= st_acc;
        bus.mem_addr <= ld_acc ? {bus.ld_addr[31:2], 2'b00} : {bus.st_addr[31:2], 2'b00};
        bus.mem_wstrb <= ld_acc ? 4'b0000 : (sb ? 4'b0001 << bus.st_addr[1:0] : 4'b1111);
        bus.mem_wdata <= ld_acc ? 32'd0 : (sb ? {4{bus.st_data[7:0]}} : bus.st_data);
      end
      if (done) begin
        bus.ld_done <= is_ld;
        bus.st_done <= !is_ld;
        if (is_ld) begin
          bus.ld_done_pc <= pc_q;
          bus.ld_done_data <= lb_q ? {{24{rd_byte[7]}}, rd_byte} : bus.mem_rdata;
        end else bus.st_done_pc <= pc_q;
      end
    end
endmodule

// File: tb/tb_mem_port_sched.sv
// tb_mem_port_sched: directed test-plan cases plus random traffic checked against a transaction-level model
module tb_mem_port_sched;
  localparam int LIM = 4;
  logic clk = 1'b0;
  logic rstn = 1'b0;
  mem_port_sched_if bus();
  mem_port_sched #(.STARVE_LIMIT(LIM)) dut (.clk(clk), .rstn(rstn), .bus(bus));
  always #5 clk = ~clk;
  int n_chk = 0;
  int n_err = 0;
  bit m_busy, m_rst, t_ld, t_lb, auto_ack;
  int m_streak;
  logic [1:0] t_lane;
  logic [31:0] t_pc;
  logic e_ld_done, e_st_done, e_err, e_we;
  logic [31:0] e_ld_pc, e_ld_data, e_st_pc, e_addr, e_wdata;
  logic [3:0] e_wstrb;
  logic [9:0] gseq;
  int gcnt;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask
  function automatic logic [31:0] load_value(input bit lb, input logic [1:0] lane, input logic [31:0] w);
    int b;
    b = int'((w >> (8 * int'(lane))) & 32'hff);
    if (!lb) return w;
    return b >= 128 ? 32'(b - 256) : 32'(b);
  endfunction
  task automatic step();
    bit lg, sg, ok;
    int lane;
    if (auto_ack) bus.mem_ack = bus.mem_req;
    #1;
    lg = rstn && !m_busy && bus.ld_valid && (!bus.st_valid || m_streak == LIM);
    sg = rstn && !m_busy && bus.st_valid && !lg;
    check("ld_ready", 32'(bus.ld_ready), 32'(lg));
    check("st_ready", 32'(bus.st_ready), 32'(sg));
    if ((lg || sg) && gcnt < 10) begin
      gseq = {gseq[8:0], lg};
      gcnt++;
    end
    e_ld_done = 0;
    e_st_done = 0;
    e_err = 0;
    if (!rstn) begin
      m_busy = 0; m_rst = 1; m_streak = 0;
      e_ld_pc = 0; e_ld_data = 0; e_st_pc = 0;
      e_addr = 0; e_we = 0; e_wstrb = 0; e_wdata = 0;
    end else if (m_busy) begin
      if (bus.mem_ack) begin
        m_busy = 0;
        if (t_ld) begin
          e_ld_done = 1; e_ld_pc = t_pc; e_ld_data = load_value(t_lb, t_lane, bus.mem_rdata);
        end else begin
          e_st_done = 1; e_st_pc = t_pc;
        end
      end
    end else if (lg || sg) begin
      m_streak = (lg || !bus.ld_valid) ? 0 : (m_streak < LIM ? m_streak + 1 : LIM);
      ok = lg ? (bus.ld_op == 7 || (bus.ld_op == 8 && bus.ld_addr % 4 == 0))
              : (bus.st_op == 9 || (bus.st_op == 10 && bus.st_addr % 4 == 0));
      if (!ok) begin
        e_err = 1;
        if (lg) begin
          e_ld_done = 1; e_ld_pc = bus.ld_pc; e_ld_data = 0;
        end else begin
          e_st_done = 1; e_st_pc = bus.st_pc;
        end
      end else begin
        m_busy = 1;
        t_ld = lg;
        t_lb = lg && bus.ld_op == 7;
        t_pc = lg ? bus.ld_pc : bus.st_pc;
        t_lane = 2'((lg ? bus.ld_addr : bus.st_addr) % 4);
        e_addr = (lg ? bus.ld_addr : bus.st_addr) / 4 * 4;
        e_we = sg;
        lane = int'(t_lane);
        e_wstrb = lg ? 4'd0 : (bus.st_op == 9 ? 4'(1 << lane) : 4'd15);
        e_wdata = (bus.st_data % 256) * 32'h01010101;
        if (bus.st_op == 10) e_wdata = bus.st_data;
      end
    end
    @(posedge clk);
    #1;
    check("ld_done", 32'(bus.ld_done), 32'(e_ld_done));
    check("st_done", 32'(bus.st_done), 32'(e_st_done));
    check("done_err", 32'(bus.done_err), 32'(e_err));
    check("ld_done_pc", bus.ld_done_pc, e_ld_pc);
    check("ld_done_data", bus.ld_done_data, e_ld_data);
    check("st_done_pc", bus.st_done_pc, e_st_pc);
    check("mem_req", 32'(bus.mem_req), 32'(m_busy));
    if (m_busy || m_rst) begin
      check("mem_addr", bus.mem_addr, e_addr);
      check("mem_we", 32'(bus.mem_we), 32'(e_we));
      check("mem_wstrb", 32'(bus.mem_wstrb), 32'(e_wstrb));
      if (e_we || m_rst) check("mem_wdata", bus.mem_wdata, e_wdata);
    end
    m_rst = 0;
  endtask
  task automatic quiet();
    bus.ld_valid = 0; bus.st_valid = 0; bus.mem_ack = 0;
  endtask
  task automatic load(input logic [3:0] op, input logic [31:0] a, input logic [31:0] pc);
    bus.ld_valid = 1; bus.ld_op = op; bus.ld_addr = a; bus.ld_pc = pc;
  endtask
  task automatic store(input logic [3:0] op, input logic [31:0] a, input logic [31:0] d, input logic [31:0] pc);
    bus.st_valid = 1; bus.st_op = op; bus.st_addr = a; bus.st_data = d; bus.st_pc = pc;
  endtask
  task automatic ack(input logic [31:0] rd);
    bus.mem_ack = 1; bus.mem_rdata = rd;
    step();
    bus.mem_ack = 0;
  endtask
  initial begin
    logic [31:0] r, a;
    logic [3:0] op;
    auto_ack = 0; m_busy = 0; m_rst = 0; m_streak = 0; gcnt = 10; gseq = '0;
    quiet();
    load(0, 0, 0); store(0, 0, 0, 0); quiet(); bus.mem_rdata = 0;
    @(posedge clk); #1;
    step(); step();
    rstn = 1;
    load(8, 32'h100, 32'h40); step(); quiet();
    check("lw_addr", bus.mem_addr, 32'h100);
    check("lw_we", 32'(bus.mem_we), 0);
    ack(32'hDEADBEEF);
    check("lw_done", 32'(bus.ld_done), 1);
    check("lw_data", bus.ld_done_data, 32'hDEADBEEF);
    check("lw_pc", bus.ld_done_pc, 32'h40);
    load(7, 32'h103, 32'h44); step(); quiet(); ack(32'h80FF0011);
    check("lb3_data", bus.ld_done_data, 32'hFFFFFF80);
    load(7, 32'h101, 32'h48); step(); quiet(); ack(32'h80FF0011);
    check("lb1_data", bus.ld_done_data, 32'h0);
    store(9, 32'h202, 32'h12345678, 32'h50); step(); quiet();
    check("sb_wstrb", 32'(bus.mem_wstrb), 32'b0100);
    check("sb_wdata", bus.mem_wdata, 32'h78787878);
    check("sb_we", 32'(bus.mem_we), 1);
    ack(0);
    check("sb_done_pc", bus.st_done_pc, 32'h50);
    store(10, 32'h204, 32'hCAFEF00D, 32'h54); step(); quiet();
    check("sw_wstrb", 32'(bus.mem_wstrb), 32'hF);
    ack(0);
    load(8, 32'h102, 32'h58); step(); quiet();
    check("lw_mis_err", 32'(bus.done_err), 1);
    check("lw_mis_req", 32'(bus.mem_req), 0);
    store(8, 32'h300, 0, 32'h5C); step(); quiet();
    check("st_bad_done", 32'(bus.st_done), 1);
    check("st_bad_err", 32'(bus.done_err), 1);
    step();
    gcnt = 0; auto_ack = 1;
    load(8, 32'h400, 32'h60); store(10, 32'h500, 32'h1, 32'h64);
    repeat (24) step();
    auto_ack = 0; quiet(); step();
    check("starve_order", 32'(gseq), 32'b0000100001);
    store(10, 32'h600, 32'h77, 32'h68); step(); quiet(); step();
    rstn = 0; step();
    check("rst_req", 32'(bus.mem_req), 0);
    check("rst_st_done", 32'(bus.st_done), 0);
    rstn = 1; bus.mem_ack = 1; step(); bus.mem_ack = 0; step();
    check("stray_ack", 32'(bus.st_done), 0);
    repeat (3000) begin
      r = $urandom;
      bus.ld_valid = r[0]; bus.st_valid = r[1]; bus.mem_ack = r[2] | r[3];
      bus.mem_rdata = $urandom;
      op = (r[7:4] == 0) ? 4'($urandom) : (r[8] ? 4'd8 : 4'd7);
      a = $urandom;
      if (op == 8 && r[10:9] != 0) a[1:0] = 0;
      bus.ld_op = op; bus.ld_addr = a; bus.ld_pc = $urandom;
      op = (r[14:11] == 0) ? 4'($urandom) : (r[15] ? 4'd10 : 4'd9);
      a = $urandom;
      if (op == 10 && r[17:16] != 0) a[1:0] = 0;
      bus.st_op = op; bus.st_addr = a; bus.st_data = $urandom; bus.st_pc = $urandom;
      rstn = r[31:24] != 0;
      step();
    end
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
